sprite_control: RTL and testbench

- Control FSM directly upstream of the sprite datapath; generates the datapath's plot_en, erase, update and datapath-reset strobes and the VGA write enable.
- Sequences one-time screen clear, then a repeating frame loop: draw 4x4 sprite, wait frame tick, erase sprite, step position.
- Consumes the datapath's plotCounter, xCounter, yCounter and freq outputs as status.

---
 rtl/sprite_control.sv | 111 +++++++++++
 tb/tb_sprite_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_control.sv
// sprite_control: control FSM sitting directly upstream of the sprite datapath.
// It clears the screen once after reset. It then loops forever:
// draw the 4x4 sprite, wait for a frame tick, erase the sprite, step its position.
// All outputs are registered and decoded from the next state, so they are valid
// in the same cycle that the state is entered.
// Optional build macro: SPRITE_CTRL_PAUSE_EN adds a 'pause' input that freezes
// the WAIT state while it is high.
module sprite_control #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int SPRITE_PIX  = 16,
  parameter int FRAME_TICKS = 12499999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
`ifdef SPRITE_CTRL_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [5:0]  plot_count,
  input  logic [7:0]  x_count,
  input  logic [6:0]  y_count,
  input  logic [25:0] freq,
  output logic        plot_en,
  output logic        erase,
  output logic        update,
  output logic        dp_reset,
  output logic        write_en,
  output logic [7:0]  frame_count,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] CLEAR  = 3'd2;
  localparam logic [2:0] DRAW   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] ERASE  = 3'd5;
  localparam logic [2:0] UPDATE = 3'd6;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       clear_done;
  logic       pass_done;
  logic       tick;
  logic       frame_go;
  logic       unused_status;

  // Status compares are exact equality. A plot_count that overshoots the
  // wrap value never ends a pass.
  assign clear_done = (y_count == 7'(SCREEN_H));
  assign pass_done  = (plot_count == 6'(SPRITE_PIX));
  assign tick       = (freq == 26'(FRAME_TICKS));

`ifdef SPRITE_CTRL_PAUSE_EN
  // Pause only gates the tick seen by WAIT. A DRAW or ERASE pass in progress
  // still runs to completion.
  assign frame_go = tick && !pause;
`else
  assign frame_go = tick;
`endif

  // The datapath already advances x within each row, so the end of the clear
  // is decided from y_count alone.
  assign unused_status = ^{x_count, 8'(SCREEN_W)};

  // Next-state decode for the clear pass and the draw/wait/erase/update loop.
  always_comb begin
    next_state = state;
    case (state)
      INIT:    next_state = IDLE;
      IDLE:    if (go)         next_state = CLEAR;
      CLEAR:   if (clear_done) next_state = DRAW;
      DRAW:    if (pass_done)  next_state = WAIT;
      WAIT:    if (frame_go)   next_state = ERASE;
      ERASE:   if (pass_done)  next_state = UPDATE;
      UPDATE:  next_state = DRAW;
      default: next_state = INIT;
    endcase
  end

  // State register and Moore outputs registered from the next state.
  // dp_reset is the one exception: it is registered from the current state.
  // This lets it pulse on the cycle that follows INIT, which is the cycle in
  // which IDLE is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      plot_en     <= 1'b0;
      erase       <= 1'b0;
      update      <= 1'b0;
      dp_reset    <= 1'b0;
      write_en    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state    <= next_state;
      plot_en  <= (next_state == DRAW)  || (next_state == ERASE);
      erase    <= (next_state == CLEAR) || (next_state == ERASE);
      write_en <= (next_state == CLEAR) || (next_state == DRAW) ||
                  (next_state == ERASE);
      update   <= (next_state == UPDATE);
      dp_reset <= (state == INIT);
      if (next_state == UPDATE) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sprite_control.sv
// tb_sprite_control: scoreboard bench for sprite_control.
// The stimulus tasks push the expected output snapshot after each clock.
// A monitor pops each snapshot and compares it with the DUT outputs, either
// on the falling edge or just after an asynchronous reset is raised.
module tb_sprite_control;

  localparam int FT = 99;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ERASE  = 3'd5;
  localparam logic [2:0] S_UPDATE = 3'd6;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        go         = 1'b0;
  logic        pause      = 1'b0;
  logic [5:0]  plot_count = 6'd0;
  logic [7:0]  x_count    = 8'd0;
  logic [6:0]  y_count    = 7'd0;
  logic [25:0] freq       = 26'd0;
  logic        plot_en;
  logic        erase;
  logic        update;
  logic        dp_reset;
  logic        write_en;
  logic [7:0]  frame_count;
  logic [2:0]  state_dbg;

  sprite_control #(
    .SCREEN_W   (160),
    .SCREEN_H   (120),
    .SPRITE_PIX (16),
    .FRAME_TICKS(FT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
`ifdef SPRITE_CTRL_PAUSE_EN
    .pause      (pause),
`endif
    .plot_count (plot_count),
    .x_count    (x_count),
    .y_count    (y_count),
    .freq       (freq),
    .plot_en    (plot_en),
    .erase      (erase),
    .update     (update),
    .dp_reset   (dp_reset),
    .write_en   (write_en),
    .frame_count(frame_count),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       pe;
    logic       er;
    logic       up;
    logic       dr;
    logic       we;
    logic [7:0] fc;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   fc_exp = 0;

  // Expected strobes for each state, written out by hand as {plot_en, erase, update, write_en}.
  function automatic exp_t mk(input logic [2:0] st, input logic dr, input string nm);
    exp_t       e;
    logic [3:0] s;
    case (st)
      S_CLEAR:  s = 4'b0101;
      S_DRAW:   s = 4'b1001;
      S_ERASE:  s = 4'b1101;
      S_UPDATE: s = 4'b0010;
      default:  s = 4'b0000;
    endcase
    e.st = st;
    e.pe = s[3];
    e.er = s[2];
    e.up = s[1];
    e.we = s[0];
    e.dr = dr;
    e.fc = 8'(fc_exp);
    e.nm = nm;
    return e;
  endfunction

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic g, input int pc, input int y, input int f,
                     input logic p, input logic [2:0] st, input logic dr,
                     input string nm);
    go         = g;
    plot_count = 6'(pc);
    y_count    = 7'(y);
    freq       = 26'(f);
    pause      = p;
    x_count    = 8'($urandom_range(0, 159));
    @(posedge clk);
    #1;
    q.push_back(mk(st, dr, nm));
  endtask

  // One full loop, starting and ending in DRAW.
  // mode 0: normal loop.
  // mode 1: frame ticks land during DRAW and must be missed.
  // mode 2: pause is held through DRAW and through three ticks in WAIT.
  task automatic frame(input int mode);
    logic p;
    p = (mode == 2);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, i, 0, (mode == 1 && i == 3) ? FT : 0, p, S_DRAW, 1'b0, "draw");
    cyc(1'b0, 20, 0, 0, p, S_DRAW, 1'b0, "draw_pc_over");
    cyc(1'b0, 16, 0, (mode == 1) ? FT : 0, p, S_WAIT, 1'b0, "draw_done");
    if (mode == 2) begin
      cyc(1'b0, 0, 0, FT, 1'b1, S_WAIT, 1'b0, "pause_tick1");
      cyc(1'b0, 0, 0, 50, 1'b1, S_WAIT, 1'b0, "pause_hold");
      cyc(1'b0, 0, 0, FT, 1'b1, S_WAIT, 1'b0, "pause_tick2");
      cyc(1'b0, 0, 0, 50, 1'b1, S_WAIT, 1'b0, "pause_hold");
      cyc(1'b0, 0, 0, FT, 1'b1, S_WAIT, 1'b0, "pause_tick3");
      cyc(1'b0, 0, 0, 50, 1'b0, S_WAIT, 1'b0, "unpause_no_tick");
    end else begin
      cyc(1'b0, 0, 0, 50, 1'b0, S_WAIT, 1'b0, "wait_hold");
    end
    cyc(1'b0, 0, 0, FT, 1'b0, S_ERASE, 1'b0, "wait_tick");
    for (int i = 0; i < 16; i++)
      cyc(1'b0, i, 0, 0, 1'b0, S_ERASE, 1'b0, "erase");
    fc_exp = (fc_exp + 1) % 256;
    cyc(1'b0, 16, 0, 0, 1'b0, S_UPDATE, 1'b0, "update");
    cyc(1'b0, 0, 0, 0, 1'b0, S_DRAW, 1'b0, "redraw");
  endtask

  // Monitor: compare each queued snapshot with the DUT outputs.
  always begin
    @(negedge clk or posedge reset);
    if (reset) #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({state_dbg, plot_en, erase, update, dp_reset, write_en, frame_count} !==
          {e.st, e.pe, e.er, e.up, e.dr, e.we, e.fc}) begin
        fails++;
        $display("FAIL %s @%0t: got st=%0d pe=%b er=%b up=%b dr=%b we=%b fc=%0d, expected st=%0d pe=%b er=%b up=%b dr=%b we=%b fc=%0d",
                 e.nm, $time, state_dbg, plot_en, erase, update, dp_reset, write_en,
                 frame_count, e.st, e.pe, e.er, e.up, e.dr, e.we, e.fc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk(S_INIT, 1'b0, "reset_hold"));
    @(negedge clk);
    #2;
    reset = 1'b0;

    cyc(1'b0, 0, 0, 0, 1'b0, S_IDLE, 1'b1, "init_dp_reset");
    cyc(1'b0, 0, 0, 0, 1'b0, S_IDLE, 1'b0, "idle_hold");
    cyc(1'b0, 16, 120, FT, 1'b0, S_IDLE, 1'b0, "idle_no_go");
    cyc(1'b1, 0, 0, 0, 1'b0, S_CLEAR, 1'b0, "go_to_clear");

    for (int y = 0; y <= 120; y++)
      cyc(1'b0, 16, y, FT, 1'b0, (y == 120) ? S_DRAW : S_CLEAR, 1'b0,
          (y == 120) ? "clear_done" : "clear");

    frame(1);
    for (int n = 1; n < 256; n++) frame(0);

`ifdef SPRITE_CTRL_PAUSE_EN
    frame(2);
`endif

    for (int i = 0; i < 16; i++)
      cyc(1'b0, i, 0, 0, 1'b0, S_DRAW, 1'b0, "draw_pre_abort");
    cyc(1'b0, 16, 0, 0, 1'b0, S_WAIT, 1'b0, "draw_done_pre_abort");
    cyc(1'b0, 0, 0, FT, 1'b0, S_ERASE, 1'b0, "tick_pre_abort");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, i, 0, 0, 1'b0, S_ERASE, 1'b0, "erase_pre_abort");
    @(negedge clk);
    #1;
    fc_exp = 0;
    q.push_back(mk(S_INIT, 1'b0, "async_reset_mid_erase"));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    cyc(1'b0, 0, 0, 0, 1'b0, S_IDLE, 1'b1, "reinit_dp_reset");
    cyc(1'b0, 0, 0, 0, 1'b0, S_IDLE, 1'b0, "reidle");
    cyc(1'b1, 0, 0, 0, 1'b0, S_CLEAR, 1'b0, "reclear");

    repeat (2) @(negedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
